// File: rtl/loopback_pkg.sv
// Shared types and the test-pattern definition for the Avalon-MM loopback master.
package loopback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_INDEX     = 2'd0,
    MODE_INV_INDEX = 2'd1,
    MODE_CHECKER   = 2'd2,
    MODE_SEED_XOR  = 2'd3
  } mode_e;

  localparam logic [31:0] CHECKER_ODD  = 32'h5555_5555;
  localparam logic [31:0] CHECKER_EVEN = 32'hAAAA_AAAA;

  // Word written to (and expected back from) word index idx.
  function automatic logic [31:0] pattern_word(input mode_e      mode,
                                               input logic [31:0] seed,
                                               input logic [31:0] idx);
    logic [31:0] word;
    word = idx;
    case (mode)
      MODE_INDEX:     word = idx;
      MODE_INV_INDEX: word = ~idx;
      MODE_CHECKER:   word = idx[0] ? CHECKER_ODD : CHECKER_EVEN;
      MODE_SEED_XOR:  word = seed ^ idx;
      default:        word = idx;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/loopback_pattern_gen.sv
// Combinational pattern generator: (mode, seed, idx) -> 32-bit test word.
import loopback_pkg::*;

module loopback_pattern_gen #(
  parameter int unsigned IDX_W = 13
) (
  input  logic [1:0]       i_mode,
  input  logic [31:0]      i_seed,
  input  logic [IDX_W-1:0] i_idx,
  output logic [31:0]      o_word
);

  assign o_word = pattern_word(mode_e'(i_mode), i_seed, 32'(i_idx));

endmodule

// File: rtl/avalon_mm_loopback_master.sv
// Avalon-MM master: writes NUM_WORDS generated words from BASE_ADDR, reads them
// back one at a time, compares and reports a pass/fail summary.
import loopback_pkg::*;

module avalon_mm_loopback_master #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NUM_WORDS = 6144,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       error_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [TMR_W-1:0]  r_timer;
  logic [1:0]        r_mode;
  logic [31:0]       r_seed;
  logic [ADDR_W-1:0] r_address;
  logic              r_write;
  logic              r_read;
  logic [31:0]       r_writedata;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [15:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_first_err;

  logic              w_start_ok;
  logic              w_last;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [31:0]       w_cmp_word;
  logic [31:0]       w_nxt_word;
  logic [1:0]        w_nxt_mode;
  logic [31:0]       w_nxt_seed;
  logic [IDX_W-1:0]  w_nxt_idx;
  logic              w_rd_done;
  logic              w_mismatch;
  logic [15:0]       w_err_next;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
    return ADDR_W'(BASE_ADDR) + {idx, 2'b00};
  endfunction

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_idx_inc  = r_idx + 1'b1;

  // The write data is registered one word ahead, so the generator for the write
  // path looks at the word being loaded next: word 0 with the incoming mode/seed
  // on start acceptance, otherwise idx+1 with the latched mode/seed.
  assign w_nxt_mode = w_start_ok ? mode : r_mode;
  assign w_nxt_seed = w_start_ok ? seed : r_seed;
  assign w_nxt_idx  = w_start_ok ? '0   : w_idx_inc;

  loopback_pattern_gen #(.IDX_W(IDX_W)) u_gen_wr (
    .i_mode (w_nxt_mode),
    .i_seed (w_nxt_seed),
    .i_idx  (w_nxt_idx),
    .o_word (w_nxt_word)
  );

  loopback_pattern_gen #(.IDX_W(IDX_W)) u_gen_cmp (
    .i_mode (r_mode),
    .i_seed (r_seed),
    .i_idx  (r_idx),
    .o_word (w_cmp_word)
  );

  // A read completes either in RD_WAIT or, for a zero-latency slave, in the
  // very cycle RD_REQ is accepted.
  assign w_rd_done  = ((r_state == ST_RD_REQ) && !avm_waitrequest && avm_readdatavalid) ||
                      ((r_state == ST_RD_WAIT) && avm_readdatavalid);
  assign w_mismatch = (avm_readdata != w_cmp_word);
  assign w_err_next = (w_mismatch && (r_err_cnt != 16'hFFFF)) ? r_err_cnt + 16'd1 : r_err_cnt;

  // Control FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_timer     <= '0;
      r_mode      <= '0;
      r_seed      <= '0;
      r_address   <= '0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_writedata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_rd_done) begin
      r_err_cnt <= w_err_next;
      if (w_mismatch && (r_err_cnt == '0)) begin
        r_first_err <= r_address;
      end
      if (w_last) begin
        r_read  <= 1'b0;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
        r_pass  <= (w_err_next == '0);
        r_state <= ST_DONE;
      end else begin
        r_idx     <= w_idx_inc;
        r_address <= word_addr(w_idx_inc);
        r_read    <= 1'b1;
        r_state   <= ST_RD_REQ;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_mode      <= mode;
            r_seed      <= seed;
            r_idx       <= '0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_write     <= 1'b1;
            r_address   <= word_addr('0);
            r_writedata <= w_nxt_word;
            r_state     <= ST_WR;
          end
        end
        ST_WR: begin
          if (!avm_waitrequest) begin
            if (w_last) begin
              r_idx     <= '0;
              r_write   <= 1'b0;
              r_read    <= 1'b1;
              r_address <= word_addr('0);
              r_state   <= ST_RD_REQ;
            end else begin
              r_idx       <= w_idx_inc;
              r_address   <= word_addr(w_idx_inc);
              r_writedata <= w_nxt_word;
            end
          end
        end
        ST_RD_REQ: begin
          if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_timer <= '0;
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign avm_address    = r_address;
  assign avm_write      = r_write;
  assign avm_read       = r_read;
  assign avm_writedata  = r_writedata;
  assign avm_byteenable = 4'hF;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign timeout        = r_timeout;
  assign error_count    = r_err_cnt;
  assign first_err_addr = r_first_err;

endmodule
